fetch_unit: RTL and testbench

//  Instruction-fetch stage of the single-issue MIPS core. Holds the PC, drives the

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit_pc_next_sel.sv | 34 +++
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: widths, PC step, IF/ID record, state enum.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int JIDX_W  = 26;

    localparam logic [PC_W-1:0]    PC_STEP   = 32'd4;
    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0000;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc4;
    } ifid_t;

    // J-type target: upper nibble of the delay-slot address, index, word aligned.
    function automatic logic [PC_W-1:0] jump_target(input logic [PC_W-1:0]   pc4,
                                                    input logic [JIDX_W-1:0] idx);
        return {pc4[PC_W-1:PC_W-4], idx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, IF/ID handshake, redirect inputs, fault.
// Latency: n/a (wiring only).
// Backpressure: id_valid/id_ready handshake toward decode.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [PC_W-1:0]    id_pc;
    logic [PC_W-1:0]    id_pc4;
    logic               br_taken;
    logic [PC_W-1:0]    br_target;
    logic               jmp;
    logic [JIDX_W-1:0]  jmp_index;
    logic               fault;

    modport master (
        output imem_addr, id_valid, id_instr, id_pc, id_pc4, fault,
        input  imem_instr, id_ready, br_taken, br_target, jmp, jmp_index
    );

    modport slave (
        input  imem_addr, id_valid, id_instr, id_pc, id_pc4, fault,
        output imem_instr, id_ready, br_taken, br_target, jmp, jmp_index
    );

endinterface

// File: rtl/fetch_unit_pc_next_sel.sv
// Next-PC selector: branch beats jump beats sequential pc+4; flags redirect flushes.
// Latency: combinational.
// Backpressure: none; the caller decides whether the selected PC is loaded.
module pc_next_sel
    import cpu_pkg::*;
(
    input  logic [PC_W-1:0]   pc,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    input  logic              jmp,
    input  logic [JIDX_W-1:0] jmp_index,
    input  logic [PC_W-1:0]   id_pc4,
    input  logic              id_valid,
    output logic [PC_W-1:0]   next_pc,
    output logic              flush
);

    // A jump request is only meaningful while its instruction sits live in IF/ID.
    logic jmp_live;
    assign jmp_live = jmp && id_valid;

    always_comb begin
        next_pc = pc + PC_STEP;
        flush   = 1'b0;
        if (br_taken) begin
            next_pc = br_target;
            flush   = 1'b1;
        end else if (jmp_live) begin
            next_pc = jump_target(id_pc4, jmp_index);
            flush   = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, same-cycle ROM lookup, IF/ID register; optional FETCH_FAULT_EN range check.
// Latency: word at imem_addr=P appears as id_pc=P one edge later; one bubble after each redirect.
// Backpressure: IF/ID and PC hold while id_valid && !id_ready; redirects override the stall.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     IMEM_BYTES = 80
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    logic [PC_W-1:0] pc;
    ifid_t           ifid;
    logic            id_valid_q;
    fetch_state_t    state;

    logic [PC_W-1:0] next_pc;
    logic            flush;
    logic            advance;
    logic            load;

    pc_next_sel u_pc_next_sel (
        .pc        (pc),
        .br_taken  (bus.br_taken),
        .br_target (bus.br_target),
        .jmp       (bus.jmp),
        .jmp_index (bus.jmp_index),
        .id_pc4    (ifid.pc4),
        .id_valid  (id_valid_q),
        .next_pc   (next_pc),
        .flush     (flush)
    );

    assign advance = !id_valid_q || bus.id_ready;
    assign load    = flush || advance;

`ifdef FETCH_FAULT_EN
    logic fault_q;
    logic bad_pc;

    // Any PC outside the word-aligned program window stops the fetch engine.
    assign bad_pc = (next_pc[1:0] != 2'b00) || (next_pc >= PC_W'(IMEM_BYTES));
    assign bus.fault = fault_q;
`else
    logic unused_imem_bytes;
    assign unused_imem_bytes = (IMEM_BYTES == 0);
    assign bus.fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            ifid       <= '{instr: INSTR_NOP, pc: '0, pc4: '0};
            id_valid_q <= 1'b0;
            state      <= FS_RUN;
`ifdef FETCH_FAULT_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            case (state)
                FS_RUN: begin
                    if (load) begin
`ifdef FETCH_FAULT_EN
                        if (bad_pc) begin
                            fault_q    <= 1'b1;
                            id_valid_q <= 1'b0;
                            state      <= FS_HALT;
                        end else
`endif
                        begin
                            pc <= next_pc;
                            if (flush) begin
                                id_valid_q <= 1'b0;
                            end else begin
                                ifid       <= '{instr: bus.imem_instr, pc: pc, pc4: pc + PC_STEP};
                                id_valid_q <= 1'b1;
                            end
                        end
                    end
                end
                FS_HALT: begin
                    id_valid_q <= 1'b0;
                end
                default: begin
                    state <= FS_RUN;
                end
            endcase
        end
    end

    assign bus.imem_addr = pc;
    assign bus.id_valid  = id_valid_q;
    assign bus.id_instr  = ifid.instr;
    assign bus.id_pc     = ifid.pc;
    assign bus.id_pc4    = ifid.pc4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written fault/wrap sequences,
// then randomized traffic against a behavioural fetch model.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned IMEM_BYTES = 80;
`ifdef FETCH_FAULT_EN
    localparam bit FAULT_ON = 1'b1;
`else
    localparam bit FAULT_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.imem_instr = rom(bus.imem_addr);

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic drive(input bit r, input bit rdy, input bit bt, input logic [31:0] btg,
                         input bit j, input logic [25:0] ji);
        rst_n         = r;
        bus.id_ready  = rdy;
        bus.br_taken  = bt;
        bus.br_target = btg;
        bus.jmp       = j;
        bus.jmp_index = ji;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          r;
        bit          rdy;
        bit          bt;
        logic [31:0] btg;
        bit          j;
        logic [25:0] ji;
        logic [31:0] eaddr;
        bit          evld;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit rdy, bit bt, logic [31:0] btg, bit j, logic [25:0] ji,
                                logic [31:0] eaddr, bit evld, logic [31:0] epc);
        vec_t v;
        v.r = r; v.rdy = rdy; v.bt = bt; v.btg = btg; v.j = j; v.ji = ji;
        v.eaddr = eaddr; v.evld = evld; v.epc = epc;
        return v;
    endfunction

    // Behavioural reference: program counter plus the word last handed to decode.
    logic [31:0] m_pc, m_p, m_i;
    bit          m_v, m_f, m_h;

    function automatic bit pc_bad(input logic [31:0] a);
        return FAULT_ON && ((a % 4) != 0 || a >= IMEM_BYTES);
    endfunction

    task automatic model_step(input bit r, input bit rdy, input bit bt, input logic [31:0] btg,
                              input bit j, input logic [25:0] ji);
        logic [31:0] dest;
        logic [31:0] seq;
        bit          fetches;
        if (!r) begin
            m_pc = RESET_PC; m_p = 0; m_i = 0; m_v = 0; m_f = 0; m_h = 0;
            return;
        end
        if (m_h) begin
            m_v = 0;
            return;
        end
        fetches = 0;
        seq     = m_p + 4;
        if (bt)                dest = btg;
        else if (j && m_v)     dest = {seq[31:28], ji, 2'b00};
        else if (!m_v || rdy) begin
            dest    = m_pc + 4;
            fetches = 1;
        end else return;
        if (pc_bad(dest)) begin
            m_f = 1; m_v = 0; m_h = 1;
            return;
        end
        if (fetches) begin
            m_i = rom(m_pc);
            m_p = m_pc;
        end
        m_v  = fetches;
        m_pc = dest;
    endtask

    initial begin
        drive(0, 1, 0, 0, 0, 0);

        vecs.push_back(mk(0, 1, 0, 0,     0, 0, 32'h00, 0, 32'h00));
        vecs.push_back(mk(1, 1, 0, 0,     0, 0, 32'h04, 1, 32'h00));
        vecs.push_back(mk(1, 1, 0, 0,     0, 0, 32'h08, 1, 32'h04));
        vecs.push_back(mk(1, 1, 0, 0,     0, 0, 32'h0C, 1, 32'h08));
        vecs.push_back(mk(1, 1, 0, 0,     0, 0, 32'h10, 1, 32'h0C));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h10, 1, 32'h0C));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1, 1, 0, 0, 0, 0, 32'h14 + 4*k, 1, 32'h10 + 4*k));
        vecs.push_back(mk(1, 1, 1, 32'h3C, 0, 0, 32'h3C, 0, 32'h00));
        vecs.push_back(mk(1, 1, 0, 0,      0, 0, 32'h40, 1, 32'h3C));
        vecs.push_back(mk(1, 1, 1, 32'h30, 0, 0, 32'h30, 0, 32'h00));
        vecs.push_back(mk(1, 1, 0, 0,      0, 0, 32'h34, 1, 32'h30));
        vecs.push_back(mk(1, 1, 0, 0,      1, 7, 32'h1C, 0, 32'h00));
        vecs.push_back(mk(1, 1, 0, 0,      0, 0, 32'h20, 1, 32'h1C));
        vecs.push_back(mk(1, 1, 1, 32'h34, 1, 7, 32'h34, 0, 32'h00));
        vecs.push_back(mk(1, 1, 0, 0,      0, 0, 32'h38, 1, 32'h34));
        vecs.push_back(mk(1, 1, 1, 32'h10, 0, 0, 32'h10, 0, 32'h00));
        vecs.push_back(mk(1, 1, 0, 0,      1, 7, 32'h14, 1, 32'h10));
        vecs.push_back(mk(1, 0, 1, 32'h08, 0, 0, 32'h08, 0, 32'h00));
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 32'h0C, 1, 32'h08));
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 32'h0C, 1, 32'h08));

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].rdy, vecs[i].bt, vecs[i].btg, vecs[i].j, vecs[i].ji);
            tick();
            chk($sformatf("vec%0d imem_addr", i), bus.imem_addr, vecs[i].eaddr);
            chk($sformatf("vec%0d id_valid", i), 32'(bus.id_valid), 32'(vecs[i].evld));
            chk($sformatf("vec%0d fault", i), 32'(bus.fault), 32'h0);
            if (vecs[i].evld || !vecs[i].r) begin
                chk($sformatf("vec%0d id_pc", i), bus.id_pc, vecs[i].epc);
                chk($sformatf("vec%0d id_pc4", i), bus.id_pc4, vecs[i].r ? vecs[i].epc + 4 : 32'h0);
                chk($sformatf("vec%0d id_instr", i), bus.id_instr, vecs[i].r ? rom(vecs[i].epc) : 32'h0);
            end
        end

        // Jump far outside the program window, then try to redirect out of it.
        drive(0, 1, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 0); tick();
        chk("farjmp pre addr", bus.imem_addr, 32'h4);
        drive(1, 1, 0, 0, 1, 26'h40); tick();
        chk("farjmp addr", bus.imem_addr, FAULT_ON ? 32'h4 : 32'h100);
        chk("farjmp valid", 32'(bus.id_valid), 32'h0);
        chk("farjmp fault", 32'(bus.fault), FAULT_ON ? 32'h1 : 32'h0);
        drive(1, 1, 1, 32'h8, 0, 0); tick();
        chk("halt br addr", bus.imem_addr, FAULT_ON ? 32'h4 : 32'h8);
        chk("halt br fault", 32'(bus.fault), FAULT_ON ? 32'h1 : 32'h0);
        drive(1, 1, 0, 0, 0, 0); tick();
        chk("halt hold addr", bus.imem_addr, FAULT_ON ? 32'h4 : 32'hC);
        chk("halt hold valid", 32'(bus.id_valid), FAULT_ON ? 32'h0 : 32'h1);
        drive(0, 1, 0, 0, 0, 0); tick();
        chk("rst clears fault", 32'(bus.fault), 32'h0);
        chk("rst pc", bus.imem_addr, RESET_PC);

        // Sequential fetch running off the last word of the window.
        drive(1, 1, 1, 32'h4C, 0, 0); tick();
        chk("edge br addr", bus.imem_addr, 32'h4C);
        drive(1, 1, 0, 0, 0, 0); tick();
        chk("edge adv addr", bus.imem_addr, FAULT_ON ? 32'h4C : 32'h50);
        chk("edge adv valid", 32'(bus.id_valid), FAULT_ON ? 32'h0 : 32'h1);
        chk("edge adv fault", 32'(bus.fault), FAULT_ON ? 32'h1 : 32'h0);

        // Misaligned branch target.
        drive(0, 1, 0, 0, 0, 0); tick();
        drive(1, 1, 1, 32'h2, 0, 0); tick();
        chk("misalign addr", bus.imem_addr, FAULT_ON ? 32'h0 : 32'h2);
        chk("misalign fault", 32'(bus.fault), FAULT_ON ? 32'h1 : 32'h0);

        // 32-bit wrap of the sequential PC.
        drive(0, 1, 0, 0, 0, 0); tick();
        drive(1, 1, 1, 32'hFFFF_FFFC, 0, 0); tick();
        chk("wrap br addr", bus.imem_addr, FAULT_ON ? 32'h0 : 32'hFFFF_FFFC);
        drive(1, 1, 0, 0, 0, 0); tick();
        chk("wrap addr", bus.imem_addr, 32'h0);
        chk("wrap valid", 32'(bus.id_valid), FAULT_ON ? 32'h0 : 32'h1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            bit          r, rdy, bt, j;
            logic [31:0] btg;
            logic [25:0] ji;
            r   = (n == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            bt  = ($urandom_range(0, 7) == 0);
            btg = 32'($urandom_range(0, 23)) * 4;
            if ($urandom_range(0, 15) == 0) btg = btg + 2;
            if (!FAULT_ON && $urandom_range(0, 31) == 0) btg = $urandom;
            j   = ($urandom_range(0, 5) == 0);
            ji  = 26'($urandom_range(0, 23));
            drive(r, rdy, bt, btg, j, ji);
            model_step(r, rdy, bt, btg, j, ji);
            tick();
            chk("rnd imem_addr", bus.imem_addr, m_pc);
            chk("rnd id_valid", 32'(bus.id_valid), 32'(m_v));
            chk("rnd fault", 32'(bus.fault), 32'(m_f));
            if (m_v) begin
                chk("rnd id_pc", bus.id_pc, m_p);
                chk("rnd id_pc4", bus.id_pc4, m_p + 4);
                chk("rnd id_instr", bus.id_instr, m_i);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
